// File: rtl/mu0_ctrl.sv
// MU0 control unit: fetch/execute sequencer with a req/ack memory handshake,
// decoding the IR opcode into datapath enables, mux selects and ALU function.
module mu0_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ir_op,
    input  logic       acc_z,
    input  logic       acc_n,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_rnw,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] alufs,
    output logic       pc_en,
    output logic       ir_en,
    output logic       acc_en,
    output logic       halted,
    output logic       illegal,
    output logic       retire
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t state;
    logic   fetch_done;
    logic   exec_done;
    logic   stop;

    // Decode is gated by reset so every output drops the moment reset asserts,
    // even with a memory access in flight.
    always_comb begin
        mem_req    = 1'b0;
        mem_rnw    = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        alufs      = 2'b00;
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        acc_en     = 1'b0;
        fetch_done = 1'b0;
        exec_done  = 1'b0;
        stop       = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    mem_rnw = 1'b1;
                    bsel    = 1'b1;
                    alufs   = 2'b01;
                    if (mem_ack) begin
                        ir_en      = 1'b1;
                        pc_en      = 1'b1;
                        fetch_done = 1'b1;
                    end
                end
                EXEC: begin
                    case (ir_op)
                        4'd0: begin
                            mem_req = 1'b1;
                            mem_rnw = 1'b1;
                            asel    = 1'b1;
                            if (mem_ack) begin
                                acc_en    = 1'b1;
                                exec_done = 1'b1;
                            end
                        end
                        4'd1: begin
                            mem_req = 1'b1;
                            asel    = 1'b1;
                            if (mem_ack) exec_done = 1'b1;
                        end
                        4'd2, 4'd3: begin
                            mem_req = 1'b1;
                            mem_rnw = 1'b1;
                            asel    = 1'b1;
                            alufs   = {1'b1, ir_op[0]};
                            if (mem_ack) begin
                                acc_en    = 1'b1;
                                exec_done = 1'b1;
                            end
                        end
                        4'd4, 4'd5, 4'd6: begin
                            bsel      = 1'b1;
                            exec_done = 1'b1;
                            pc_en     = (ir_op == 4'd4)
                                     || ((ir_op == 4'd5) && !acc_n)
                                     || ((ir_op == 4'd6) && !acc_z);
                        end
                        4'd7: stop = 1'b1;
                        default: begin
                            if (ILLEGAL_HALT) stop = 1'b1;
                            else              exec_done = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
        retire = exec_done || stop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: if (fetch_done) state <= EXEC;
                EXEC: begin
                    if (exec_done) begin
                        state <= FETCH;
                    end else if (stop) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        if (ir_op[3]) illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mu0_ctrl.md
Name: mu0_ctrl

Overview:
- Control unit that sequences the MU0 16-bit datapath: PC, IR and ACC registers, the address and B-input muxes, and the 2-bit-function ALU (alufs).
- Runs a fetch/execute state machine with a req/ack memory handshake.
- Decodes the 4-bit IR opcode and drives every datapath enable and select.
- Sits beside the datapath at the processor top level.

Parameters:
- ILLEGAL_HALT, 1: 1 = opcodes 8-15 halt the core and raise illegal; 0 = they execute as a 1-cycle NOP.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir_op  in  4  IR[15:12], the current instruction opcode.
- acc_z  in  1  ACC == 0, from the datapath.
- acc_n  in  1  ACC[15], from the datapath.
- mem_ack  in  1  memory access complete; read data is valid in this cycle.
- mem_req  out  1  memory access request.
- mem_rnw  out  1  1 = read, 0 = write of ACC.
- asel  out  1  address mux: 0 = PC, 1 = IR[11:0].
- bsel  out  1  ALU B mux: 0 = memory read data, 1 = PC/IR (fetch: PC, execute: IR[11:0]).
- alufs  out  2  ALU function: 00 B, 01 B+1, 10 A+B, 11 A-B.
- pc_en  out  1  PC load from ALU.
- ir_en  out  1  IR load from memory data.
- acc_en  out  1  ACC load from ALU.
- halted  out  1  core stopped.
- illegal  out  1  sticky: an illegal opcode was executed.
- retire  out  1  1-cycle pulse when an instruction completes.

Behaviour:
- States: FETCH, EXEC, HALT. State register reset is asynchronous on reset=0 and forces FETCH.
- While reset=0, every output is 0, including illegal and halted.
- All outputs except halted/illegal are combinational decodes of state, ir_op, acc_z, acc_n and mem_ack. Register enables assert only in the completing cycle.
- FETCH:
  - Drive mem_req=1, mem_rnw=1, asel=0, bsel=1, alufs=01.
  - Hold until mem_ack. In the ack cycle assert ir_en=1 and pc_en=1 (PC <- PC+1), then go to EXEC.
- EXEC by ir_op:
  - 0 LDA: req read, asel=1, bsel=0, alufs=00. On ack: acc_en=1.
  - 1 STO: req write (mem_rnw=0), asel=1. On ack: no enables.
  - 2 ADD: read, asel=1, bsel=0, alufs=10. On ack: acc_en=1.
  - 3 SUB: as ADD with alufs=11.
  - 4 JMP: no req. bsel=1, alufs=00, pc_en=1. Completes in 1 cycle.
  - 5 JGE: as JMP, but pc_en=!acc_n.
  - 6 JNE: as JMP, but pc_en=!acc_z.
  - 7 STP: no req, no enables. Go to HALT.
  - 8-15: if ILLEGAL_HALT=1, act as STP and set illegal=1. Otherwise NOP: 1 cycle, no enables.
- Completion and retire:
  - Instructions with a memory access complete on mem_ack. Jumps and NOP complete in 1 cycle.
  - On completion, pulse retire=1 and return to FETCH.
  - STP (and illegal with ILLEGAL_HALT=1) pulses retire in the EXEC cycle.
- Memory-side rules:
  - While waiting for ack, mem_req, mem_rnw, asel, bsel and alufs stay stable.
  - mem_ack while mem_req=0 is ignored.
  - mem_req deasserts combinationally in the cycle after ack, because the state has advanced. Back-to-back requests FETCH -> EXEC are legal, and mem_req may remain 1 across the boundary.
- HALT: halted=1 (registered). No outputs asserted, mem_ack ignored. Only reset leaves HALT.
- Reset mid-access (asserted while mem_req is high and ack is pending): mem_req drops immediately and no enable fires. After release, restart in FETCH.
- Timing: zero-wait memory gives 2 cycles per ALU/memory instruction and 2 cycles per jump.

Test Plan:
- Reset release, mem_ack tied 1, ir_op=2 -> cycle 0 FETCH: mem_req=1, asel=0, alufs=01, ir_en=pc_en=1. Cycle 1 EXEC: asel=1, bsel=0, alufs=10, acc_en=1, retire=1.
- Fetch with mem_ack delayed 3 cycles -> mem_req=1 and selects stable for 3 cycles, ir_en=0 throughout. ir_en/pc_en=1 only in the ack cycle.
- ir_op=5: with acc_n=1 -> pc_en=0, retire=1. With acc_n=0 -> pc_en=1, alufs=00, bsel=1. Likewise ir_op=6 with acc_z.
- ir_op=1, ack after 2 cycles -> mem_rnw=0, asel=1, no acc_en/pc_en/ir_en, retire on the ack cycle.
- ir_op=7 -> next cycle halted=1, mem_req stays 0 for 20 cycles despite mem_ack=1. Reset clears halted to 0.
- ir_op=9: with ILLEGAL_HALT=1 -> halted=1, illegal=1. With ILLEGAL_HALT=0 -> 1-cycle NOP, illegal=0, back to FETCH.
- Reset asserted mid-LDA with ack pending -> mem_req=0 and acc_en=0 asynchronously. After release the first cycle is FETCH.
